// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared access-size encodings, response record and load/address helpers
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8002_0000;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  function automatic logic [2:0] access_bytes(input logic [1:0] size);
    case (size)
      SZ_WORD: return 3'd4;
      SZ_HALF: return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  // Range check runs in 33 bits so an offset near 2^32 cannot wrap back into range.
  function automatic logic access_error(input logic [31:0] off, input logic [1:0] size,
                                        input logic [32:0] mem_bytes);
    logic [32:0] last;
    logic        misaligned;
    last = {1'b0, off} + 33'(access_bytes(size)) - 33'd1;
    case (size)
      SZ_WORD: misaligned = |off[1:0];
      SZ_HALF: misaligned = off[0];
      default: misaligned = 1'b0;
    endcase
    return (last >= mem_bytes) || misaligned;
  endfunction

  // raw holds the four bytes starting at the access address, lowest address in bits 31..24.
  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] size,
                                              input logic sgn);
    case (size)
      SZ_WORD: return raw;
      SZ_HALF: return {{16{sgn & raw[31]}}, raw[31:16]};
      default: return {{24{sgn & raw[31]}}, raw[31:24]};
    endcase
  endfunction

endpackage

// File: rtl/dual_port_memory_if.sv
// rtl/dual_port_memory_if.sv - instruction and data port bundle for dual_port_memory
interface dual_port_memory_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic        d_signed;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_size, d_signed, d_wdata,
    input  i_valid, i_data, i_err, d_valid, d_rdata, d_err
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_size, d_signed, d_wdata,
    output i_valid, i_data, i_err, d_valid, d_rdata, d_err
  );
endinterface

// File: rtl/mem_resp_pipe.sv
// rtl/mem_resp_pipe.sv - capture register followed by DEPTH delay stages for one response port
module mem_resp_pipe
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 0
) (
  input  logic  clock,
  input  logic  reset_n,
  input  resp_t in_resp,
  output resp_t out_resp
);

  // Stage 0 is the capture register; DEPTH = 0 exposes it directly.
  resp_t stages [DEPTH+1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= in_resp;
      for (int i = 1; i <= DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign out_resp = stages[DEPTH];

endmodule

// File: rtl/dual_port_memory.sv
// rtl/dual_port_memory.sv - byte-addressed big-endian memory with read-only I-port and read/write D-port
module dual_port_memory
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1048576,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned LATENCY   = 1
) (
  input logic              clock,
  input logic              reset_n,
  dual_port_memory_if.slave bus
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  logic [7:0]    mem [MEM_BYTES];
  logic [31:0]   i_off, d_off;
  logic [AW-1:0] i_idx, d_idx;
  logic          i_bad, d_bad;
  logic [31:0]   i_raw, d_raw;
  resp_t         i_resp, d_resp, i_out, d_out;

  always_comb begin
    i_off = bus.i_addr - BASE_ADDR;
    d_off = bus.d_addr - BASE_ADDR;
    i_bad = access_error(i_off, SZ_WORD, 33'(MEM_BYTES));
    d_bad = access_error(d_off, bus.d_size, 33'(MEM_BYTES));
    i_idx = i_off[AW-1:0];
    d_idx = d_off[AW-1:0];
    // Reads see the array before this edge's write lands, giving read-before-write.
    i_raw = {mem[i_idx], mem[i_idx + AW'(1)], mem[i_idx + AW'(2)], mem[i_idx + AW'(3)]};
    d_raw = {mem[d_idx], mem[d_idx + AW'(1)], mem[d_idx + AW'(2)], mem[d_idx + AW'(3)]};

    i_resp.valid = bus.i_req;
    i_resp.err   = bus.i_req & i_bad;
    i_resp.data  = (bus.i_req && !i_bad) ? i_raw : 32'h0;

    d_resp.valid = bus.d_req;
    d_resp.err   = bus.d_req & d_bad;
    d_resp.data  = (bus.d_req && !bus.d_we && !d_bad)
                   ? load_extend(d_raw, bus.d_size, bus.d_signed) : 32'h0;
  end

  // Array is deliberately never reset; requests are still ignored while reset is held.
  always_ff @(posedge clock) begin
    if (reset_n && bus.d_req && bus.d_we && !d_bad) begin
      case (bus.d_size)
        SZ_WORD: begin
          mem[d_idx]          <= bus.d_wdata[31:24];
          mem[d_idx + AW'(1)] <= bus.d_wdata[23:16];
          mem[d_idx + AW'(2)] <= bus.d_wdata[15:8];
          mem[d_idx + AW'(3)] <= bus.d_wdata[7:0];
        end
        SZ_HALF: begin
          mem[d_idx]          <= bus.d_wdata[15:8];
          mem[d_idx + AW'(1)] <= bus.d_wdata[7:0];
        end
        default: mem[d_idx] <= bus.d_wdata[7:0];
      endcase
    end
  end

  mem_resp_pipe #(.DEPTH(LATENCY - 1)) u_i_pipe (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_resp  (i_resp),
    .out_resp (i_out)
  );

  mem_resp_pipe #(.DEPTH(LATENCY - 1)) u_d_pipe (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_resp  (d_resp),
    .out_resp (d_out)
  );

  assign bus.i_valid = i_out.valid;
  assign bus.i_err   = i_out.err;
  assign bus.i_data  = i_out.data;
  assign bus.d_valid = d_out.valid;
  assign bus.d_err   = d_out.err;
  assign bus.d_rdata = d_out.data;

endmodule

// File: tb/tb_dual_port_memory.sv
// tb/tb_dual_port_memory.sv - directed bench for dual_port_memory at latency 1 (dut a) and 3 (dut b)
module tb_dual_port_memory;

  logic clock;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  dual_port_memory_if a ();
  dual_port_memory_if b ();

  dual_port_memory #(.MEM_BYTES(65536), .BASE_ADDR(32'h8002_0000), .LATENCY(1)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .bus(a)
  );
  dual_port_memory #(.MEM_BYTES(65536), .BASE_ADDR(32'h8002_0000), .LATENCY(3)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .bus(b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic a_d(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                     input logic sg, input logic [31:0] wd,
                     output logic v, output logic [31:0] rd, output logic e);
    @(negedge clock);
    a.d_req = 1'b1; a.d_we = we; a.d_addr = addr; a.d_size = sz; a.d_signed = sg; a.d_wdata = wd;
    @(posedge clock); #1;
    v = a.d_valid; rd = a.d_rdata; e = a.d_err;
    a.d_req = 1'b0;
  endtask

  task automatic a_i(input logic [31:0] addr, output logic v, output logic [31:0] rd,
                     output logic e);
    @(negedge clock);
    a.i_req = 1'b1; a.i_addr = addr;
    @(posedge clock); #1;
    v = a.i_valid; rd = a.i_data; e = a.i_err;
    a.i_req = 1'b0;
  endtask

  task automatic b_d(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                     input logic [31:0] wd, output int lat, output logic [31:0] rd,
                     output logic e);
    @(negedge clock);
    b.d_req = 1'b1; b.d_we = we; b.d_addr = addr; b.d_size = sz; b.d_signed = 1'b0; b.d_wdata = wd;
    @(posedge clock); #1;
    b.d_req = 1'b0;
    lat = 0;
    while (!b.d_valid && lat < 8) begin
      @(posedge clock); #1;
      lat++;
    end
    rd = b.d_rdata; e = b.d_err;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    a.i_req = 0; a.i_addr = 0; a.d_req = 0; a.d_we = 0; a.d_addr = 0; a.d_size = 0; a.d_signed = 0; a.d_wdata = 0;
    b.i_req = 0; b.i_addr = 0; b.d_req = 0; b.d_we = 0; b.d_addr = 0; b.d_size = 0; b.d_signed = 0; b.d_wdata = 0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if ({a.i_valid, a.i_err, a.d_valid, a.d_err} !== 4'b0) begin n_bad++; $display("FAIL reset_a_flags: got %b exp 0000", {a.i_valid, a.i_err, a.d_valid, a.d_err}); end
    n_cmp++; if ({a.i_data, a.d_rdata} !== 64'h0) begin n_bad++; $display("FAIL reset_a_data: got %h exp 0", {a.i_data, a.d_rdata}); end
    n_cmp++; if ({b.i_valid, b.i_err, b.d_valid, b.d_err} !== 4'b0) begin n_bad++; $display("FAIL reset_b_flags: got %b exp 0000", {b.i_valid, b.i_err, b.d_valid, b.d_err}); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_word_roundtrip;
    logic v, e; logic [31:0] rd;
    a_d(1'b1, 32'h8002_0010, 2'b11, 1'b0, 32'hDEAD_BEEF, v, rd, e);
    n_cmp++; if ({v, e, rd} !== {1'b1, 1'b0, 32'h0}) begin n_bad++; $display("FAIL rt_write_resp: got v=%b e=%b d=%h exp v=1 e=0 d=0", v, e, rd); end
    a_d(1'b0, 32'h8002_0010, 2'b11, 1'b0, 32'h0, v, rd, e);
    n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL rt_valid: got %b exp 1", v); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rt_rdata: got %h exp deadbeef", rd); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL rt_err: got %b exp 0", e); end
    @(posedge clock); #1;
    n_cmp++; if (a.d_valid !== 1'b0) begin n_bad++; $display("FAIL rt_single_pulse: got %b exp 0", a.d_valid); end
  endtask

  task automatic test_subword_loads;
    logic v, e; logic [31:0] rd;
    a_d(1'b0, 32'h8002_0010, 2'b00, 1'b0, 32'h0, v, rd, e);
    n_cmp++; if (rd !== 32'h0000_00DE) begin n_bad++; $display("FAIL lb_unsigned: got %h exp 000000de", rd); end
    a_d(1'b0, 32'h8002_0010, 2'b01, 1'b1, 32'h0, v, rd, e);
    n_cmp++; if (rd !== 32'hFFFF_FFDE) begin n_bad++; $display("FAIL lb_signed: got %h exp ffffffde", rd); end
    a_d(1'b0, 32'h8002_0012, 2'b10, 1'b0, 32'h0, v, rd, e);
    n_cmp++; if (rd !== 32'h0000_BEEF) begin n_bad++; $display("FAIL lh_unsigned: got %h exp 0000beef", rd); end
    a_d(1'b0, 32'h8002_0012, 2'b10, 1'b1, 32'h0, v, rd, e);
    n_cmp++; if (rd !== 32'hFFFF_BEEF) begin n_bad++; $display("FAIL lh_signed: got %h exp ffffbeef", rd); end
    a_d(1'b0, 32'h8002_0010, 2'b10, 1'b1, 32'h0, v, rd, e);
    n_cmp++; if (rd !== 32'hFFFF_DEAD) begin n_bad++; $display("FAIL lh_signed_hi: got %h exp ffffdead", rd); end
  endtask

  task automatic test_subword_store;
    logic v, e; logic [31:0] rd;
    a_d(1'b1, 32'h8002_0011, 2'b00, 1'b0, 32'hAAAA_AA11, v, rd, e);
    a_d(1'b0, 32'h8002_0010, 2'b11, 1'b0, 32'h0, v, rd, e);
    n_cmp++; if (rd !== 32'hDE11_BEEF) begin n_bad++; $display("FAIL sb_merge: got %h exp de11beef", rd); end
    a_d(1'b1, 32'h8002_0012, 2'b10, 1'b0, 32'h5555_CAFE, v, rd, e);
    a_d(1'b0, 32'h8002_0010, 2'b11, 1'b0, 32'h0, v, rd, e);
    n_cmp++; if (rd !== 32'hDE11_CAFE) begin n_bad++; $display("FAIL sh_merge: got %h exp de11cafe", rd); end
  endtask

  task automatic test_errors;
    logic v, e; logic [31:0] rd;
    a_d(1'b1, 32'h8002_0000, 2'b11, 1'b0, 32'h1234_5678, v, rd, e);
    a_d(1'b0, 32'h8002_0002, 2'b11, 1'b0, 32'h0, v, rd, e);
    n_cmp++; if ({v, e, rd} !== {1'b1, 1'b1, 32'h0}) begin n_bad++; $display("FAIL err_misaligned_read: got v=%b e=%b d=%h exp v=1 e=1 d=0", v, e, rd); end
    a_d(1'b1, 32'h8002_0002, 2'b11, 1'b0, 32'hFFFF_FFFF, v, rd, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL err_misaligned_write: got %b exp 1", e); end
    a_d(1'b0, 32'h8002_0000, 2'b11, 1'b0, 32'h0, v, rd, e);
    n_cmp++; if (rd !== 32'h1234_5678) begin n_bad++; $display("FAIL err_write_suppressed: got %h exp 12345678", rd); end
    a_i(32'h8001_FFFC, v, rd, e);
    n_cmp++; if ({v, e, rd} !== {1'b1, 1'b1, 32'h0}) begin n_bad++; $display("FAIL err_i_below_base: got v=%b e=%b d=%h exp v=1 e=1 d=0", v, e, rd); end
    a_d(1'b0, 32'h8002_FFFE, 2'b11, 1'b0, 32'h0, v, rd, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL err_word_past_end: got %b exp 1", e); end
    a_d(1'b0, 32'h8002_FFFC, 2'b11, 1'b0, 32'h0, v, rd, e);
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL err_last_word: got %b exp 0", e); end
    a_d(1'b0, 32'h8002_FFFF, 2'b00, 1'b0, 32'h0, v, rd, e);
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL err_last_byte: got %b exp 0", e); end
    a_d(1'b0, 32'h8003_0000, 2'b00, 1'b0, 32'h0, v, rd, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL err_byte_past_end: got %b exp 1", e); end
    a_d(1'b0, 32'h8002_0011, 2'b10, 1'b0, 32'h0, v, rd, e);
    n_cmp++; if ({e, rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL err_half_odd: got e=%b d=%h exp e=1 d=0", e, rd); end
    a_i(32'h8002_0010, v, rd, e);
    n_cmp++; if ({v, e, rd} !== {1'b1, 1'b0, 32'hDE11_CAFE}) begin n_bad++; $display("FAIL i_read_ok: got v=%b e=%b d=%h exp v=1 e=0 d=de11cafe", v, e, rd); end
  endtask

  task automatic test_pipeline;
    int lat; logic e; logic [31:0] rd;
    logic        got_v [8];
    logic [31:0] got_d [8];
    for (int k = 0; k < 4; k++)
      b_d(1'b1, 32'h8002_0100 + 32'(4 * k), 2'b11, 32'hA000_0001 + 32'(k), lat, rd, e);
    b_d(1'b0, 32'h8002_0104, 2'b11, 32'h0, lat, rd, e);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL pipe_d_latency: got %0d exp 2", lat); end
    n_cmp++; if (rd !== 32'hA000_0002) begin n_bad++; $display("FAIL pipe_d_rdata: got %h exp a0000002", rd); end
    @(negedge clock);
    b.i_req = 1'b1; b.i_addr = 32'h8002_0100;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock); #1;
      got_v[c] = b.i_valid; got_d[c] = b.i_data;
      if (c < 3) b.i_addr = 32'h8002_0100 + 32'(4 * (c + 1));
      else b.i_req = 1'b0;
    end
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if (got_v[c] !== (c >= 2 && c <= 5)) begin n_bad++; $display("FAIL pipe_i_valid[%0d]: got %b exp %b", c, got_v[c], (c >= 2 && c <= 5)); end
      if (c >= 2 && c <= 5) begin
        n_cmp++;
        if (got_d[c] !== 32'hA000_0001 + 32'(c - 2)) begin n_bad++; $display("FAIL pipe_i_data[%0d]: got %h exp %h", c, got_d[c], 32'hA000_0001 + 32'(c - 2)); end
      end
    end
  endtask

  task automatic test_same_edge;
    int wait_c;
    @(negedge clock);
    b.d_req = 1'b1; b.d_we = 1'b1; b.d_addr = 32'h8002_0100; b.d_size = 2'b11; b.d_wdata = 32'h55AA_55AA;
    b.i_req = 1'b1; b.i_addr = 32'h8002_0100;
    @(posedge clock); #1;
    b.d_req = 1'b0; b.i_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if ({b.i_valid, b.i_data} !== {1'b1, 32'hA000_0001}) begin n_bad++; $display("FAIL same_edge_old: got v=%b d=%h exp v=1 d=a0000001", b.i_valid, b.i_data); end
    n_cmp++; if ({b.d_valid, b.d_err} !== 2'b10) begin n_bad++; $display("FAIL same_edge_d_resp: got %b exp 10", {b.d_valid, b.d_err}); end
    @(negedge clock);
    b.i_req = 1'b1;
    @(posedge clock); #1;
    b.i_req = 1'b0;
    wait_c = 0;
    while (!b.i_valid && wait_c < 8) begin
      @(posedge clock); #1;
      wait_c++;
    end
    n_cmp++; if ({b.i_valid, b.i_data} !== {1'b1, 32'h55AA_55AA}) begin n_bad++; $display("FAIL same_edge_new: got v=%b d=%h exp v=1 d=55aa55aa", b.i_valid, b.i_data); end
  endtask

  task automatic test_midflight_reset;
    int lat; logic e; logic [31:0] rd; logic stale;
    @(negedge clock);
    b.d_req = 1'b1; b.d_we = 1'b0; b.d_addr = 32'h8002_0104; b.d_size = 2'b11;
    b.i_req = 1'b1; b.i_addr = 32'h8002_0108;
    @(posedge clock); #1;
    b.d_addr = 32'h8002_0108;
    @(posedge clock); #1;
    b.d_req = 1'b0; b.i_req = 1'b0;
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({b.i_valid, b.i_err, b.d_valid, b.d_err} !== 4'b0) begin n_bad++; $display("FAIL mid_reset_flags: got %b exp 0000", {b.i_valid, b.i_err, b.d_valid, b.d_err}); end
    n_cmp++; if ({b.i_data, b.d_rdata} !== 64'h0) begin n_bad++; $display("FAIL mid_reset_data: got %h exp 0", {b.i_data, b.d_rdata}); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); #1;
      stale |= b.d_valid | b.i_valid | a.d_valid | a.i_valid;
    end
    n_cmp++; if (stale !== 1'b0) begin n_bad++; $display("FAIL mid_reset_stale: got %b exp 0", stale); end
    b_d(1'b0, 32'h8002_0104, 2'b11, 32'h0, lat, rd, e);
    n_cmp++; if ({lat == 2, e, rd} !== {1'b1, 1'b0, 32'hA000_0002}) begin n_bad++; $display("FAIL mid_reset_retained: got lat=%0d e=%b d=%h exp lat=2 e=0 d=a0000002", lat, e, rd); end
  endtask

  initial begin
    test_reset();
    test_word_roundtrip();
    test_subword_loads();
    test_subword_store();
    test_errors();
    test_pipeline();
    test_same_edge();
    test_midflight_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
